// File: rtl/rv_instr_encoder.sv
`timescale 1ns/1ps
// rv_instr_encoder
// Packs opcode, register fields, funct fields and a 32-bit signed byte-offset
// immediate into one RV32I instruction word. The immediate is range-checked
// and alignment-checked for the format implied by the opcode. If a request
// cannot be encoded, the block emits the canonical NOP and an error code.
//
// Pipeline: S1 registers the raw request. S2 registers the encoded result.
// A request accepted in cycle N is presented in cycle N+2. The block sustains
// one request per cycle.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     request handshake
//   in_opcode..in_imm     request fields (imm is signed, unscaled)
//   out_valid/out_ready   result handshake
//   out_instr             encoded word (0x00000013 on error)
//   out_err/out_err_code  0 none, 1 range, 2 misaligned, 3 illegal opcode
//   enc_count/err_count   saturating counts of output transfers / error transfers
module rv_instr_encoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       in_opcode,
   input  logic [4:0]       in_rd,
   input  logic [2:0]       in_funct3,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [6:0]       in_funct7,
   input  logic [31:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_err,
   output logic [1:0]       out_err_code,
   output logic [CNT_W-1:0] enc_count,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_R      = 7'b0110011;

   localparam logic [31:0] NOP = 32'h0000_0013;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_RANGE   = 2'd1;
   localparam logic [1:0] ERR_ALIGN   = 2'd2;
   localparam logic [1:0] ERR_ILLEGAL = 2'd3;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [6:0]  funct7;
      logic [31:0] imm;
   } req_t;

   req_t        in_req;
   req_t        s1;
   logic        s1_valid;
   logic        s2_free;

   logic [31:0] raw;
   logic        illegal;
   logic        rng_err;
   logic        aln_err;
   logic [1:0]  enc_code;
   logic [31:0] enc_instr;

   // Fit tests: the bits above the top immediate bit of each format must all
   // copy the sign. An I/S immediate is a 12-bit value, a B immediate is 13 bits,
   // and a J immediate is 21 bits.
   logic        fit_i;
   logic        fit_b;
   logic        fit_j;

   assign in_req = {in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_funct7, in_imm};

   // There is no skid buffer, so in_ready depends combinationally on out_ready.
   assign s2_free  = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_free;

   assign fit_i = (s1.imm[31:11] == {21{s1.imm[31]}});
   assign fit_b = (s1.imm[31:12] == {20{s1.imm[31]}});
   assign fit_j = (s1.imm[31:20] == {12{s1.imm[31]}});

   always_comb begin
      raw     = NOP;
      illegal = 1'b0;
      rng_err = 1'b0;
      aln_err = 1'b0;
      case (s1.opcode)
         OP_R: raw = {s1.funct7, s1.rs2, s1.rs1, s1.funct3, s1.rd, s1.opcode};
         OP_IMM: begin
            // SLLI/SRLI/SRAI: funct7 supplies the upper bits and shamt is 5 bits wide.
            if (s1.funct3 == 3'b001 || s1.funct3 == 3'b101) begin
               raw     = {s1.funct7, s1.imm[4:0], s1.rs1, s1.funct3, s1.rd, s1.opcode};
               rng_err = |s1.imm[31:5];
            end else begin
               raw     = {s1.imm[11:0], s1.rs1, s1.funct3, s1.rd, s1.opcode};
               rng_err = !fit_i;
            end
         end
         OP_LOAD, OP_JALR: begin
            raw     = {s1.imm[11:0], s1.rs1, s1.funct3, s1.rd, s1.opcode};
            rng_err = !fit_i;
         end
         OP_STORE: begin
            raw     = {s1.imm[11:5], s1.rs2, s1.rs1, s1.funct3, s1.imm[4:0], s1.opcode};
            rng_err = !fit_i;
         end
         OP_BRANCH: begin
            raw     = {s1.imm[12], s1.imm[10:5], s1.rs2, s1.rs1, s1.funct3,
                       s1.imm[4:1], s1.imm[11], s1.opcode};
            rng_err = !fit_b;
            aln_err = s1.imm[0];
         end
         OP_LUI, OP_AUIPC: begin
            raw     = {s1.imm[31:12], s1.rd, s1.opcode};
            aln_err = |s1.imm[11:0];
         end
         OP_JAL: begin
            raw     = {s1.imm[20], s1.imm[10:1], s1.imm[11], s1.imm[19:12], s1.rd, s1.opcode};
            rng_err = !fit_j;
            aln_err = s1.imm[0];
         end
         default: illegal = 1'b1;
      endcase

      if (illegal)      enc_code = ERR_ILLEGAL;
      else if (aln_err) enc_code = ERR_ALIGN;
      else if (rng_err) enc_code = ERR_RANGE;
      else              enc_code = ERR_NONE;

      enc_instr = (enc_code != ERR_NONE) ? NOP : raw;
   end

   // S1: raw request register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1       <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) s1 <= in_req;
      end
   end

   // S2: encoded result. Data is reloaded only when a new item moves in, so the
   // outputs stay stable while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_instr    <= '0;
         out_err      <= 1'b0;
         out_err_code <= ERR_NONE;
      end else if (s2_free) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_instr    <= enc_instr;
            out_err      <= (enc_code != ERR_NONE);
            out_err_code <= enc_code;
         end
      end
   end

   // Saturating counters. Both count output transfers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enc_count <= '0;
         err_count <= '0;
      end else if (out_valid && out_ready) begin
         if (enc_count != CNT_MAX)            enc_count <= enc_count + 1'b1;
         if (out_err && err_count != CNT_MAX) err_count <= err_count + 1'b1;
      end
   end

endmodule
